serial_frame_tx: RTL and testbench

//   Transmit end of the team's single-wire serial link. Accepts one DATA_W-bit word per

---
 rtl/serial_frame_tx.sv | 189 ++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//   Transmit end of the single-wire serial link. Takes one DATA_W-bit word per
//   valid/ready handshake and sends it on tx_line as a bit-timed frame:
//   start bit (0), data LSB first, optional even parity bit, stop bit (1).
//   Every line bit is held for CLKS_PER_BIT clock cycles.
//
// Parameters
//   DATA_W        data bits per frame (>=1)
//   CLKS_PER_BIT  clk cycles each line bit is held (>=1)
//   PARITY_EN     1: even parity bit after the data, 0: no parity bit
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous reset, active-high, overrides everything
//   tx_data   in   word to send, sampled only on the handshake edge
//   tx_valid  in   producer has a word on tx_data
//   tx_ready  out  block can accept a word (high only while idle)
//   tx_line   out  serial output, idles high
//   busy      out  high while a frame is on the line (start..stop)
//   done      out  one-cycle pulse in the last cycle of the stop bit
//
// All outputs come straight from flops. Their next values are derived from the
// next state, so a handshake at edge k puts the start bit on the line in the
// cycle that follows edge k.
// -----------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_line,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic             PAR_ON   = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shreg_q,   shreg_d;
    logic                parity_q,  parity_d;
    logic                line_q,    line_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                ready_q,   ready_d;
    logic                bit_end_s;

    // Next-state, counter and shift-register logic.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        bit_end_s = (clk_cnt_q == CNT_MAX);

        case (state_q)
            ST_IDLE: begin
                // tx_ready mirrors the idle state, so tx_valid alone completes the handshake here.
                if (tx_valid) begin
                    state_d   = ST_START;
                    shreg_d   = tx_data;
                    parity_d  = even_parity(tx_data);
                    clk_cnt_d = CNT_ZERO;
                    bit_cnt_d = BIT_ZERO;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d   = ST_DATA;
                    clk_cnt_d = CNT_ZERO;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    clk_cnt_d = CNT_ZERO;
                    if (bit_cnt_q == BIT_MAX) begin
                        state_d   = PAR_ON ? ST_PARITY : ST_STOP;
                        bit_cnt_d = BIT_ZERO;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shreg_d   = shreg_q >> 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d   = ST_STOP;
                    clk_cnt_d = CNT_ZERO;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_d   = ST_IDLE;
                    clk_cnt_d = CNT_ZERO;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clk_cnt_d = CNT_ZERO;
                bit_cnt_d = BIT_ZERO;
            end
        endcase
    end

    // Registered outputs derived from the state being entered, so they line up with it.
    always_comb begin
        line_d = 1'b1;
        case (state_d)
            ST_IDLE:   line_d = 1'b1;
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shreg_d[0];
            ST_PARITY: line_d = parity_d;
            ST_STOP:   line_d = 1'b1;
            default:   line_d = 1'b1;
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
        done_d  = (state_d == ST_STOP) && (clk_cnt_d == CNT_MAX);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= CNT_ZERO;
            bit_cnt_q <= BIT_ZERO;
            shreg_q   <= {DATA_W{1'b0}};
            parity_q  <= 1'b0;
            line_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            line_q    <= line_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign tx_line  = line_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_ready = ready_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//   Directed bench for serial_frame_tx. dut uses the default configuration
//   (8 data bits, 4 clocks per bit, even parity); dut1 uses 1 clock per bit
//   with no parity. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_line;
    logic       busy;
    logic       done;

    logic [7:0] tx_data1;
    logic       tx_valid1;
    logic       tx_ready1;
    logic       tx_line1;
    logic       busy1;
    logic       done1;

    int n_checks;
    int n_errors;
    int done_cnt;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_line  (tx_line),
        .busy     (busy),
        .done     (done)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .tx_ready (tx_ready1),
        .tx_line  (tx_line1),
        .busy     (busy1),
        .done     (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses of the main instance.
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for tx_ready, present the word and complete one handshake.
    // Returns in cycle k+1, the first start-bit cycle.
    task automatic start_frame(input logic [7:0] w, input logic keep_valid);
        int waited;
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        check_eq("ready_wait", {31'd0, tx_ready}, 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    // Check the 44 cycles of one frame of the main instance, starting in cycle k+1.
    // par is the hand-computed parity bit. glitch pulses tx_valid with 0x5A mid-frame.
    task automatic check_frame(input string tag, input logic [7:0] w, input logic par,
                               input logic glitch);
        logic [10:0] fb;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = w[i];
        fb[9]  = par;
        fb[10] = 1'b1;
        for (int b = 0; b < 11; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (glitch && b == 3 && c == 0) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'h5A;
                end
                if (glitch && b == 3 && c == 1) tx_valid = 1'b0;
                check_eq($sformatf("%s_line_b%0d_c%0d", tag, b, c), {31'd0, tx_line}, {31'd0, fb[b]});
                check_eq($sformatf("%s_busy_b%0d_c%0d", tag, b, c), {31'd0, busy}, 32'd1);
                check_eq($sformatf("%s_ready_b%0d_c%0d", tag, b, c), {31'd0, tx_ready}, 32'd0);
                check_eq($sformatf("%s_done_b%0d_c%0d", tag, b, c), {31'd0, done},
                         (b == 10 && c == 3) ? 32'd1 : 32'd0);
                step();
            end
        end
        // Cycle k+45: back in idle.
        check_eq({tag, "_idle_line"},  {31'd0, tx_line},  32'd1);
        check_eq({tag, "_idle_busy"},  {31'd0, busy},     32'd0);
        check_eq({tag, "_idle_done"},  {31'd0, done},     32'd0);
        check_eq({tag, "_idle_ready"}, {31'd0, tx_ready}, 32'd1);
    endtask

    initial begin
        int dc0;
        int waited;
        n_checks  = 0;
        n_errors  = 0;
        done_cnt  = 0;
        rst       = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data1  = 8'h00;
        tx_valid1 = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state.
        check_eq("rst_line",   {31'd0, tx_line},   32'd1);
        check_eq("rst_busy",   {31'd0, busy},      32'd0);
        check_eq("rst_done",   {31'd0, done},      32'd0);
        check_eq("rst_ready",  {31'd0, tx_ready},  32'd1);
        check_eq("rst_line1",  {31'd0, tx_line1},  32'd1);
        check_eq("rst_ready1", {31'd0, tx_ready1}, 32'd1);
        step();

        // 0xA5: 0 | 1,0,1,0,0,1,0,1 | 0 | 1, done exactly once.
        dc0 = done_cnt;
        start_frame(8'hA5, 1'b0);
        check_frame("a5", 8'hA5, 1'b0, 1'b0);
        check_eq("a5_done_count", done_cnt - dc0, 32'd1);

        // Parity one and parity zero.
        start_frame(8'h07, 1'b0);
        check_frame("x07", 8'h07, 1'b1, 1'b0);
        start_frame(8'h00, 1'b0);
        check_frame("x00", 8'h00, 1'b0, 1'b0);

        // tx_valid held high: 0x11 then 0x22 back to back with a 1-cycle idle gap.
        start_frame(8'h11, 1'b1);
        tx_data = 8'h22;
        check_frame("x11", 8'h11, 1'b0, 1'b0);
        step();
        tx_valid = 1'b0;
        check_frame("x22", 8'h22, 1'b0, 1'b0);

        // Reset during data bit 3 of 0xFF, then 0x3C.
        start_frame(8'hFF, 1'b0);
        for (int i = 0; i < 17; i++) step();
        check_eq("ff_bit3_line", {31'd0, tx_line}, 32'd1);
        check_eq("ff_bit3_busy", {31'd0, busy},    32'd1);
        dc0 = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("midrst_line",  {31'd0, tx_line},  32'd1);
        check_eq("midrst_busy",  {31'd0, busy},     32'd0);
        check_eq("midrst_ready", {31'd0, tx_ready}, 32'd1);
        for (int i = 0; i < 30; i++) begin
            check_eq($sformatf("midrst_idle_line_%0d", i), {31'd0, tx_line}, 32'd1);
            step();
        end
        check_eq("midrst_no_done", done_cnt - dc0, 32'd0);
        start_frame(8'h3C, 1'b0);
        check_frame("x3c", 8'h3C, 1'b0, 1'b0);

        // tx_valid pulse with 0x5A mid-frame must be ignored.
        start_frame(8'hC3, 1'b0);
        check_frame("glitch", 8'hC3, 1'b0, 1'b1);
        step();
        check_eq("glitch_after_busy", {31'd0, busy}, 32'd0);

        // One clock per bit, no parity: 0xFF -> 0,1,1,1,1,1,1,1,1,1.
        waited = 0;
        while (tx_ready1 !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        check_eq("c1_ready_wait", {31'd0, tx_ready1}, 32'd1);
        tx_data1  = 8'hFF;
        tx_valid1 = 1'b1;
        step();
        tx_valid1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("c1_line_%0d", i), {31'd0, tx_line1}, (i == 0) ? 32'd0 : 32'd1);
            check_eq($sformatf("c1_busy_%0d", i), {31'd0, busy1}, 32'd1);
            check_eq($sformatf("c1_done_%0d", i), {31'd0, done1}, (i == 9) ? 32'd1 : 32'd0);
            step();
        end
        check_eq("c1_ready_k11", {31'd0, tx_ready1}, 32'd1);
        check_eq("c1_busy_k11",  {31'd0, busy1},     32'd0);
        check_eq("c1_done_k11",  {31'd0, done1},     32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
